// File: rtl/mem_reader_of_verifla_pkg.sv
// Shared constants, helpers and FSM encoding for the VeriFLA capture-memory readout path.
// Default memory geometry matches config_verifla.v.
package mem_reader_of_verifla_pkg;

  localparam int DFLT_ADDRESS_BITS = 4;
  localparam int DFLT_WORDLEN_BITS = 16;
  localparam int DFLT_LAST_ADDR    = 15;

  function automatic int word_bytes(input int wordlen_bits);
    return (wordlen_bits + 7) / 8;
  endfunction

  localparam int WORD_BYTES = word_bytes(DFLT_WORDLEN_BITS);

  // Byte-index width; never zero so single-byte words still get a legal vector.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_reader_of_verifla_if.sv
// Bundle between the readout sequencer and its environment: capture-memory read port,
// start/status handshake and the valid/ready byte stream toward the UART transmitter.
interface mem_reader_of_verifla_if
  import mem_reader_of_verifla_pkg::*;
#(
  parameter int ADDR_W = DFLT_ADDRESS_BITS,
  parameter int WORD_W = DFLT_WORDLEN_BITS
) ();

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] addrb;
  logic [WORD_W-1:0] doutb;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, start_addr, doutb, out_ready,
    output addrb, out_byte, out_valid, busy, done
  );

  modport master (
    output start, start_addr, doutb, out_ready,
    input  addrb, out_byte, out_valid, busy, done
  );

endinterface

// File: rtl/mem_reader_of_verifla_serializer.sv
// Parallel-load shift register that emits one captured word as bytes, MSB first,
// on a valid/ready stream. Unused high bits of a partial top byte read as zero.
module word_serializer_of_verifla
  import mem_reader_of_verifla_pkg::*;
#(
  parameter int WORD_W  = DFLT_WORDLEN_BITS,
  parameter int N_BYTES = WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              ready_i,
  output logic [7:0]        byte_o,
  output logic              valid_o,
  output logic              word_done_o
);

  localparam int SH_W  = N_BYTES * 8;
  localparam int IDX_W = idx_bits(N_BYTES);

  logic [SH_W-1:0]  sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             xfer;

  assign xfer = valid_q & ready_i;

  always_comb begin
    sh_d    = sh_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      sh_d    = SH_W'(word_i);
      idx_d   = IDX_W'(N_BYTES - 1);
      valid_d = 1'b1;
    end else if (xfer) begin
      // Byte 0 going out ends the word; the register keeps its value so out_byte stays put.
      if (idx_q == '0) begin
        valid_d = 1'b0;
      end else begin
        sh_d  = sh_q << 8;
        idx_d = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign byte_o      = sh_q[SH_W-1 -: 8];
  assign valid_o     = valid_q;
  assign word_done_o = xfer && (idx_q == '0);

endmodule

// File: rtl/mem_reader_of_verifla.sv
// Readout sequencer: walks the circular capture memory once from start_addr and streams
// every word out MSB byte first, then pulses done.
module mem_reader_of_verifla
  import mem_reader_of_verifla_pkg::*;
#(
  parameter int LA_MEM_ADDRESS_BITS = DFLT_ADDRESS_BITS,
  parameter int LA_MEM_WORDLEN_BITS = DFLT_WORDLEN_BITS,
  parameter int LA_MEM_LAST_ADDR    = DFLT_LAST_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_reader_of_verifla_if.slave bus
);

  localparam int NBYTES = word_bytes(LA_MEM_WORDLEN_BITS);
  localparam int DEPTH  = LA_MEM_LAST_ADDR + 1;
  localparam int AW     = LA_MEM_ADDRESS_BITS;
  localparam int CNT_W  = LA_MEM_ADDRESS_BITS + 1;

  localparam logic [AW-1:0]    LAST_A  = AW'(LA_MEM_LAST_ADDR);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e           state_q;
  logic [AW-1:0]    addrb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic             ser_load;
  logic             ser_word_done;
  logic             ser_valid;
  logic [7:0]       ser_byte;

  assign ser_load = (state_q == ST_LOAD);

  word_serializer_of_verifla #(
    .WORD_W  (LA_MEM_WORDLEN_BITS),
    .N_BYTES (NBYTES)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ser_load),
    .word_i      (bus.doutb),
    .ready_i     (bus.out_ready),
    .byte_o      (ser_byte),
    .valid_o     (ser_valid),
    .word_done_o (ser_word_done)
  );

  // IDLE already registers the first address, so the first word enters at WAIT;
  // ADDR only steps to the following word, giving a fixed 3-cycle gap between words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addrb_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            addrb_q <= bus.start_addr;
            cnt_q   <= DEPTH_C;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_ADDR: begin
          addrb_q <= (addrb_q == LAST_A) ? '0 : addrb_q + 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: state_q <= ST_LOAD;
        ST_LOAD: state_q <= ST_SEND;
        ST_SEND: begin
          if (ser_word_done) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_ADDR;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.addrb     = addrb_q;
  assign bus.out_byte  = ser_byte;
  assign bus.out_valid = ser_valid;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_reader_of_verifla.sv
// Randomized bench for mem_reader_of_verifla against a queue-based model of the readout.
module tb_mem_reader_of_verifla;

  localparam int AW    = 4;
  localparam int WW    = 16;
  localparam int LAST  = 15;
  localparam int DEPTH = LAST + 1;
  localparam int WB    = (WW + 7) / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_reader_of_verifla_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();

  mem_reader_of_verifla #(
    .LA_MEM_ADDRESS_BITS (AW),
    .LA_MEM_WORDLEN_BITS (WW),
    .LA_MEM_LAST_ADDR    (LAST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Capture memory: one-cycle read latency.
  logic [WW-1:0] mem [DEPTH];
  always @(posedge clk) bus.doutb <= mem[bus.addrb];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stream monitor
  logic [7:0] byte_q[$];
  int         xcyc_q[$];
  int         addr_q[$];
  int         rise_q[$];
  int         done_cnt;
  int         done_cyc;
  logic       busy_at_done;
  logic       prev_valid;
  logic       stall;
  logic [7:0] held;
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall) chk("hold", {bus.out_valid, bus.out_byte}, {1'b1, held});
      if (bus.out_valid && !prev_valid) rise_q.push_back(cyc);
      if (bus.out_valid && bus.out_ready) begin
        if (byte_q.size() % WB == 0) addr_q.push_back(int'(bus.addrb));
        byte_q.push_back(bus.out_byte);
        xcyc_q.push_back(cyc);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = bus.busy;
      end
      stall      = bus.out_valid && !bus.out_ready;
      held       = bus.out_byte;
      prev_valid = bus.out_valid;
    end
  end

  task automatic clear_mon();
    byte_q.delete();
    xcyc_q.delete();
    addr_q.delete();
    rise_q.delete();
    done_cnt     = 0;
    done_cyc     = -1;
    busy_at_done = 1'bx;
    prev_valid   = 1'b0;
    stall        = 1'b0;
    held         = '0;
  endtask

  function automatic logic ready_for(input int rmode, input int k);
    case (rmode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return $urandom_range(0, 99) < 55;
    endcase
  endfunction

  // One full readout; rmode 0=always ready, 1=ready 1-in-3, 2=random ready.
  task automatic run_read(input string nm, input int sa, input int rmode,
                          input bit poke, input bit timing);
    logic [7:0] exp_q[$];
    int st;
    int w;
    clear_mon();
    mon_en = 1'b1;
    @(posedge clk); #1;
    bus.start_addr = AW'(sa);
    bus.start      = 1'b1;
    bus.out_ready  = ready_for(rmode, 0);
    st             = cyc;
    for (int k = 1; k < 3000 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      bus.start = poke && (k == 5 || k == 20);
      if (bus.start) bus.start_addr = AW'($urandom_range(0, LAST));
      bus.out_ready = ready_for(rmode, k);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    mon_en = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      w = 'hA000 + ((sa + i) % DEPTH);
      for (int b = WB - 1; b >= 0; b--) exp_q.push_back(8'((w >> (8 * b)) & 'hFF));
    end

    chk({nm, ":done_cnt"}, done_cnt, 1);
    chk({nm, ":nbytes"}, byte_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
      chk($sformatf("%s:byte%0d", nm, i), byte_q[i], exp_q[i]);
    for (int i = 0; i < DEPTH && i < addr_q.size(); i++)
      chk($sformatf("%s:addr%0d", nm, i), addr_q[i], (sa + i) % DEPTH);
    if (xcyc_q.size() > 0) chk({nm, ":done_after_last"}, done_cyc, xcyc_q[xcyc_q.size() - 1] + 1);
    chk({nm, ":busy_at_done"}, busy_at_done, 1'b0);

    if (timing && rise_q.size() > 0 && xcyc_q.size() == DEPTH * WB) begin
      chk({nm, ":first_valid"}, rise_q[0] - st, 3);
      chk({nm, ":last_xfer"}, xcyc_q[DEPTH * WB - 1] - st, 2 + DEPTH * (WB + 3) - 3);
      for (int i = 1; i < DEPTH && i < rise_q.size(); i++)
        chk($sformatf("%s:gap%0d", nm, i), rise_q[i] - xcyc_q[i * WB - 1], 4);
      for (int i = 0; i < DEPTH; i++)
        chk($sformatf("%s:b2b%0d", nm, i), xcyc_q[i * WB + WB - 1] - xcyc_q[i * WB], WB - 1);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WW'('hA000 + i);
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst:addrb", bus.addrb, 0);
    chk("rst:out_byte", bus.out_byte, 0);
    chk("rst:out_valid", bus.out_valid, 0);
    chk("rst:busy", bus.busy, 0);
    chk("rst:done", bus.done, 0);

    run_read("base", 0, 0, 1'b0, 1'b1);
    run_read("wrap", 13, 0, 1'b0, 1'b1);
    run_read("bp3", 0, 1, 1'b0, 1'b0);
    run_read("poke", 0, 0, 1'b1, 1'b1);

    // Abort in the middle of the 5th word.
    clear_mon();
    mon_en = 1'b1;
    @(posedge clk); #1;
    bus.start_addr = '0;
    bus.start      = 1'b1;
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 200 && byte_q.size() < 4 * WB + 1; k++) begin
      @(posedge clk); #1;
    end
    chk("abort:reached", byte_q.size() >= 4 * WB + 1, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort:out_valid", bus.out_valid, 0);
    chk("abort:busy", bus.busy, 0);
    chk("abort:done", bus.done, 0);
    chk("abort:addrb", bus.addrb, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort:no_done", done_cnt, 0);
    mon_en = 1'b0;
    run_read("after_rst", 2, 0, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++)
      run_read($sformatf("rand%0d", r), $urandom_range(0, LAST), 2, r[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
